// File: rtl/panda_pkg.sv
// panda_pkg: shared types for the Panda execute-stage multiply/divide unit.
package panda_pkg;
  typedef enum logic [1:0] {
    MD_DIV  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REM  = 2'd2,
    MD_REMU = 2'd3
  } md_op_e;
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_DONE   = 2'd2
  } div_state_e;
endpackage

// File: rtl/panda_adder.sv
// panda_adder: Width-bit adder; subtract_i selects a - b via invert-and-carry-in.
module panda_adder #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] sum_o
);
  assign sum_o = a_i + (subtract_i ? ~b_i : b_i) + Width'(subtract_i);
endmodule

// File: rtl/panda_divider.sv
// panda_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module panda_divider
  import panda_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             valid_o,
  output logic [Width-1:0] result_o
);
  div_state_e       state_q, state_d;
  md_op_e           op_q;
  logic [Width-1:0] rem_q, quo_q, dvs_q, cnt_q;
  logic             neg_q;
  logic             signed_op, rem_op, a_neg, b_neg, accept, div_zero, ovf, special, ge, last;
  logic [Width-1:0] a_mag, b_mag, special_res, quo_n, rem_n, sel, final_res;
  logic [Width:0]   shifted, diff;
  assign signed_op   = md_op_e'(op_i) == MD_DIV || md_op_e'(op_i) == MD_REM;
  assign rem_op      = md_op_e'(op_i) == MD_REM || md_op_e'(op_i) == MD_REMU;
  assign a_neg       = signed_op & dividend_i[Width-1];
  assign b_neg       = signed_op & divisor_i[Width-1];
  assign a_mag       = a_neg ? -dividend_i : dividend_i;
  assign b_mag       = b_neg ? -divisor_i : divisor_i;
  assign div_zero    = divisor_i == '0;
  assign ovf         = signed_op && dividend_i == {1'b1, {(Width-1){1'b0}}} && divisor_i == '1;
  assign special     = div_zero | ovf;
  assign special_res = div_zero ? (rem_op ? dividend_i : '1) : (rem_op ? '0 : dividend_i);
  assign ready_o     = state_q == DIV_IDLE;
  assign valid_o     = state_q == DIV_DONE;
  assign accept      = valid_i & ready_o;
  // The dividend magnitude sits in the quotient register and shifts into the remainder MSB-first.
  assign shifted = {rem_q, quo_q[Width-1]};
  panda_adder #(.Width(Width + 1)) u_sub (
    .a_i       (shifted),
    .b_i       ({1'b0, dvs_q}),
    .subtract_i(1'b1),
    .sum_o     (diff)
  );
  assign ge        = ~diff[Width];
  assign rem_n     = ge ? diff[Width-1:0] : shifted[Width-1:0];
  assign quo_n     = {quo_q[Width-2:0], ge};
  assign last      = cnt_q == Width'(1);
  assign sel       = (op_q == MD_REM || op_q == MD_REMU) ? rem_n : quo_n;
  assign final_res = neg_q ? -sel : sel;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE:   state_d = accept ? (special ? DIV_DONE : DIV_DIVIDE) : DIV_IDLE;
      DIV_DIVIDE: state_d = last ? DIV_DONE : DIV_DIVIDE;
      default:    state_d = DIV_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= DIV_IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= MD_DIV;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      op_q  <= md_op_e'(op_i);
      rem_q <= '0;
      quo_q <= a_mag;
      dvs_q <= b_mag;
      cnt_q <= Width'(Width);
      neg_q <= rem_op ? a_neg : a_neg ^ b_neg;
      if (special) result_o <= special_res;
    end else if (state_q == DIV_DIVIDE) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - Width'(1);
      if (last) result_o <= final_res;
    end
  end
endmodule

// File: tb/tb_panda_divider.sv
// tb_panda_divider: randomized scoreboard bench against an arithmetic reference model.
module tb_panda_divider;
  localparam int W = 32;
  logic         clk = 0, rst_n = 0, valid_i = 0;
  logic [1:0]   op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic         ready, valid_o;
  logic [W-1:0] result;
  panda_divider #(.Width(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready), .op_i(op),
    .dividend_i(a), .divisor_i(b), .valid_o(valid_o), .result_o(result)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [W-1:0] res; int lat; int acc;} exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0, mismatched = 0;
  logic [W-1:0] hold = 0;
  int last_acc = 0, last_lat = 0;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask
  function automatic bit is_signed(input logic [1:0] o);
    return o == 2'd0 || o == 2'd2;
  endfunction
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic rem = o == 2'd2 || o == 2'd3;
    if (y == 0) return rem ? x : '1;
    if (is_signed(o) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return rem ? '0 : x;
    if (is_signed(o)) return rem ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
    return rem ? x % y : x / y;
  endfunction
  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit chained);
    int n = 0;
    int lat;
    op = o; a = x; b = y; valid_i = 1;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: ready_o still low after %0d cycles, required high", n);
      valid_i = 0;
      return;
    end
    lat = (y == 0 || (is_signed(o) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : W + 1;
    q.push_back('{model(o, x, y), lat, cyc + 1});
    if (chained) begin
      compared++;
      if (cyc + 1 - last_acc != last_lat + 1) begin
        mismatched++;
        $display("FAIL issue_interval: got %0d required %0d", cyc + 1 - last_acc, last_lat + 1);
      end
    end
    last_acc = cyc + 1;
    last_lat = lat;
    @(negedge clk);
    check("ready_low_after_accept", W'(ready), W'(0));
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_valid: valid_o high with result %h, required no strobe", result);
        end else begin
          e = q.pop_front();
          check("result", result, e.res);
          compared++;
          if (cyc - e.acc + 1 != e.lat) begin
            mismatched++;
            $display("FAIL latency: got %0d required %0d", cyc - e.acc + 1, e.lat);
          end
          hold = e.res;
        end
      end else check("result_hold", result, hold);
    end
  end
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_ready", W'(ready), W'(1));
    check("reset_valid", W'(valid_o), W'(0));
    check("reset_result", result, '0);
    rst_n = 1;
    issue(2'd1, 100, 7, 0);
    issue(2'd3, 100, 7, 1);
    issue(2'd0, -32'sd7, 2, 1);
    issue(2'd2, -32'sd7, 2, 1);
    issue(2'd0, 7, -32'sd2, 1);
    issue(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(2'd0, 5, 0, 1);
    issue(2'd2, 5, 0, 1);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 40; i++) begin
      bit ch = 1'($urandom_range(0, 1));
      if (!ch) begin
        valid_i = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(2'($urandom_range(0, 3)), pick(), pick(), ch);
    end
    issue(2'd1, 32'hDEAD_BEEF, 3, 1);
    valid_i = 0;
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_ready", W'(ready), W'(1));
    check("abort_valid", W'(valid_o), W'(0));
    check("abort_result", result, '0);
    q.delete();
    hold = 0;
    @(negedge clk);
    rst_n = 1;
    issue(2'd1, 9, 3, 0);
    valid_i = 0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", W'(q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
